// File: rtl/tpu_tile_sequencer_pkg.sv
// Shared types and default constants for the TPU tile sequencer.
package tpu_ctrl_pkg;

  localparam int ADDRESSSIZE_D  = 10;
  localparam int MATRIX_SIZE_D  = 16;
  localparam int WLOAD_CYCLES_D = 2;
  localparam int DRAIN_CYCLES_D = 32;
  localparam int TILE_CNT_BW_D  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_W,
    ST_WLOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_WRITE,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Host job handshake plus datapath strobes of the tile sequencer.
interface tpu_seq_if
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDRESSSIZE_D,
  parameter int TILE_CNT_BW = TILE_CNT_BW_D
);
  logic                   start;
  logic [TILE_CNT_BW-1:0] num_tiles;
  logic [ADDRESSSIZE-1:0] ub_base;
  logic [ADDRESSSIZE-1:0] res_base;
  logic                   fifo_empty;
  logic                   busy;
  logic                   done;
  logic                   fifo_rd_en;
  logic                   we_rl;
  logic [ADDRESSSIZE-1:0] ub_addr;
  logic                   ub_rd_valid;
  logic                   res_we;
  logic [ADDRESSSIZE-1:0] res_addr;
  logic [TILE_CNT_BW-1:0] tile_idx;

  modport master (
    output start, num_tiles, ub_base, res_base, fifo_empty,
    input  busy, done, fifo_rd_en, we_rl, ub_addr, ub_rd_valid, res_we, res_addr, tile_idx
  );

  modport slave (
    input  start, num_tiles, ub_base, res_base, fifo_empty,
    output busy, done, fifo_rd_en, we_rl, ub_addr, ub_rd_valid, res_we, res_addr, tile_idx
  );
endinterface

// File: rtl/tpu_tile_sequencer_phase_counter.sv
// Loadable down-counter with terminal-count flag; times every fixed-length phase.
module seq_phase_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)
      r_cnt <= r_cnt - W'(1);
  end

  assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/tpu_tile_sequencer.sv
// Per-tile TPU datapath sequencer with start/busy/done host handshake.
// Optional perf counters are enabled by defining TPU_SEQ_PERF_EN.
module tpu_tile_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE  = ADDRESSSIZE_D,
  parameter int MATRIX_SIZE  = MATRIX_SIZE_D,
  parameter int WLOAD_CYCLES = WLOAD_CYCLES_D,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_D,
  parameter int TILE_CNT_BW  = TILE_CNT_BW_D
) (
  input  logic        clk,
  input  logic        rst,
  tpu_seq_if.slave    bus
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [15:0] perf_stall
`endif
);
  localparam int CNT_W = $clog2((DRAIN_CYCLES > MATRIX_SIZE) ? DRAIN_CYCLES : MATRIX_SIZE) + 1;

  seq_state_t             r_state;
  logic [TILE_CNT_BW-1:0] r_num_tiles;
  logic [TILE_CNT_BW-1:0] r_tile_idx;
  logic [ADDRESSSIZE-1:0] r_ub_next;
  logic [ADDRESSSIZE-1:0] r_res_next;
  logic [ADDRESSSIZE-1:0] r_ub_addr;
  logic [ADDRESSSIZE-1:0] r_res_addr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_fifo_rd_en;
  logic                   r_we_rl;
  logic                   r_ub_rd_valid;
  logic                   r_res_we;

  logic                   w_cnt_load;
  logic [CNT_W-1:0]       w_cnt_val;
  logic                   w_cnt_tc;
  logic                   w_last_tile;

  assign w_last_tile = (r_tile_idx == r_num_tiles - TILE_CNT_BW'(1));

  // Each phase loads its length minus one on the edge that enters it.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    unique case (r_state)
      ST_WAIT_W: if (r_fifo_rd_en) begin w_cnt_load = 1'b1; w_cnt_val = CNT_W'(WLOAD_CYCLES - 1); end
      ST_WLOAD:  if (w_cnt_tc)     begin w_cnt_load = 1'b1; w_cnt_val = CNT_W'(MATRIX_SIZE - 1);  end
      ST_STREAM: if (w_cnt_tc)     begin w_cnt_load = 1'b1; w_cnt_val = CNT_W'(DRAIN_CYCLES - 1); end
      ST_DRAIN:  if (w_cnt_tc)     begin w_cnt_load = 1'b1; w_cnt_val = CNT_W'(MATRIX_SIZE - 1);  end
      default: ;
    endcase
  end

  seq_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (1'b1),
    .o_tc       (w_cnt_tc)
  );

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch reads the pre-edge values; strobes default low and are re-asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_num_tiles   <= '0;
      r_tile_idx    <= '0;
      r_ub_next     <= '0;
      r_res_next    <= '0;
      r_ub_addr     <= '0;
      r_res_addr    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fifo_rd_en  <= 1'b0;
      r_we_rl       <= 1'b0;
      r_ub_rd_valid <= 1'b0;
      r_res_we      <= 1'b0;
    end else begin
      r_fifo_rd_en <= 1'b0;
      r_done       <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_num_tiles <= bus.num_tiles;
            r_ub_next   <= bus.ub_base;
            r_res_next  <= bus.res_base;
            r_tile_idx  <= '0;
            r_busy      <= 1'b1;
            if (bus.num_tiles == '0) begin
              r_state <= ST_FINISH;
            end else begin
              r_state      <= ST_WAIT_W;
              r_fifo_rd_en <= !bus.fifo_empty;
            end
          end
        end
        ST_WAIT_W: begin
          if (r_fifo_rd_en) begin
            r_state <= ST_WLOAD;
            r_we_rl <= 1'b1;
          end else begin
            r_fifo_rd_en <= !bus.fifo_empty;
          end
        end
        ST_WLOAD: begin
          if (w_cnt_tc) begin
            r_state       <= ST_STREAM;
            r_we_rl       <= 1'b0;
            r_ub_rd_valid <= 1'b1;
            r_ub_addr     <= r_ub_next;
            r_ub_next     <= r_ub_next + ADDRESSSIZE'(1);
          end
        end
        ST_STREAM: begin
          if (w_cnt_tc) begin
            r_state       <= ST_DRAIN;
            r_ub_rd_valid <= 1'b0;
          end else begin
            r_ub_addr <= r_ub_next;
            r_ub_next <= r_ub_next + ADDRESSSIZE'(1);
          end
        end
        ST_DRAIN: begin
          if (w_cnt_tc) begin
            r_state    <= ST_WRITE;
            r_res_we   <= 1'b1;
            r_res_addr <= r_res_next;
            r_res_next <= r_res_next + ADDRESSSIZE'(1);
          end
        end
        ST_WRITE: begin
          if (w_cnt_tc) begin
            r_res_we <= 1'b0;
            if (w_last_tile) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_WAIT_W;
              r_tile_idx   <= r_tile_idx + TILE_CNT_BW'(1);
              r_fifo_rd_en <= !bus.fifo_empty;
            end
          end else begin
            r_res_addr <= r_res_next;
            r_res_next <= r_res_next + ADDRESSSIZE'(1);
          end
        end
        ST_FINISH: begin
          // An empty job enters here with done low and spends one extra cycle.
          if (r_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic w_accept;
  logic w_stall;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_stall  = bus.fifo_empty &&
                    ((w_accept && bus.num_tiles != '0) ||
                     (r_state == ST_WAIT_W && !r_fifo_rd_en) ||
                     (r_state == ST_WRITE && w_cnt_tc && !w_last_tile));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (w_accept) begin
      perf_cycles <= '0;
      perf_stall  <= w_stall ? 16'd1 : 16'd0;
    end else begin
      if (r_busy)  perf_cycles <= perf_cycles + 32'd1;
      if (w_stall) perf_stall  <= perf_stall + 16'd1;
    end
  end
`endif

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.fifo_rd_en  = r_fifo_rd_en;
  assign bus.we_rl       = r_we_rl;
  assign bus.ub_addr     = r_ub_addr;
  assign bus.ub_rd_valid = r_ub_rd_valid;
  assign bus.res_we      = r_res_we;
  assign bus.res_addr    = r_res_addr;
  assign bus.tile_idx    = r_tile_idx;
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer; expected timelines come from the per-tile schedule.
module tb_tpu_tile_sequencer;
  import tpu_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int TW = 8;
  localparam int TILE_LAT = 67;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tpu_seq_if #(.ADDRESSSIZE(AW), .TILE_CNT_BW(TW)) bus ();

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_stall;
`endif

  tpu_tile_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef TPU_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] hold_ub  = '0;
  logic [AW-1:0] hold_res = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int n, input logic [AW-1:0] ub, input logic [AW-1:0] res);
    bus.start     = 1'b1;
    bus.num_tiles = TW'(n);
    bus.ub_base   = ub;
    bus.res_base  = res;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5+2*AW+TW:0] got;
    bus.start = 1'b0; bus.num_tiles = '0; bus.ub_base = '0; bus.res_base = '0; bus.fifo_empty = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    got = {bus.busy, bus.done, bus.fifo_rd_en, bus.we_rl, bus.ub_rd_valid, bus.res_we,
           bus.ub_addr, bus.res_addr, bus.tile_idx};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    rst = 1'b0;
    hold_ub = '0; hold_res = '0;
  endtask

  // Runs one job from start to a few cycles past done, checking every cycle.
  task automatic run_job(input string name, input int n, input logic [AW-1:0] ub,
                         input logic [AW-1:0] res, input int stall_tile, input int stall_len,
                         input int busy_start_c, input bit start_at_done, input int exp_stall);
    int p[8];
    int done_c, ns, pops, dones, off, e_tile;
    logic [5:0] got_s, exp_s;
    logic [AW-1:0] e_ub, e_res;
    p[0] = 1;
    for (int t = 1; t < n; t++) p[t] = p[t-1] + TILE_LAT + ((t == stall_tile) ? stall_len : 0);
    done_c = (n == 0) ? 2 : p[n-1] + TILE_LAT;
    ns = (stall_tile > 0) ? p[stall_tile-1] + TILE_LAT : 0;
    pops = 0; dones = 0;
    bus.fifo_empty = 1'b0;
    issue_start(n, ub, res);
    for (int c = 1; c <= done_c + 3; c++) begin
      exp_s = {(c <= done_c), (c == done_c), 4'b0000};
      e_ub = hold_ub; e_res = hold_res; e_tile = 0;
      for (int t = 0; t < n; t++) begin
        off = c - p[t];
        if (t > 0 && c >= p[t-1] + TILE_LAT) e_tile = t;
        if (off == 0) exp_s[3] = 1'b1;
        if (off >= 1 && off <= 2) exp_s[2] = 1'b1;
        if (off >= 3 && off <= 18) begin
          exp_s[1] = 1'b1;
          e_ub = ub + AW'(t * 16) + AW'(off - 3);
        end
        if (off >= 51 && off <= 66) begin
          exp_s[0] = 1'b1;
          e_res = res + AW'(t * 16) + AW'(off - 51);
        end
      end
      hold_ub = e_ub; hold_res = e_res;
      got_s = {bus.busy, bus.done, bus.fifo_rd_en, bus.we_rl, bus.ub_rd_valid, bus.res_we};
      if (bus.fifo_rd_en === 1'b1) pops++;
      if (bus.done === 1'b1) dones++;
      n_checks++;
      if (got_s !== exp_s) begin
        n_fail++;
        $display("FAIL %s strobes cycle %0d: got %b expected %b", name, c, got_s, exp_s);
      end
      n_checks++;
      if (bus.ub_addr !== e_ub) begin
        n_fail++;
        $display("FAIL %s ub_addr cycle %0d: got %h expected %h", name, c, bus.ub_addr, e_ub);
      end
      n_checks++;
      if (bus.res_addr !== e_res) begin
        n_fail++;
        $display("FAIL %s res_addr cycle %0d: got %h expected %h", name, c, bus.res_addr, e_res);
      end
      n_checks++;
      if (bus.tile_idx !== TW'(e_tile)) begin
        n_fail++;
        $display("FAIL %s tile_idx cycle %0d: got %0d expected %0d", name, c, bus.tile_idx, e_tile);
      end
      // Stimulus for the edge that ends cycle c.
      bus.fifo_empty = (stall_tile > 0) && (c >= ns - 1) && (c < ns - 1 + stall_len);
      bus.start = (c == busy_start_c) || (start_at_done && c == done_c);
      if (c == busy_start_c) begin
        bus.num_tiles = 8'd5; bus.ub_base = 10'h2AA; bus.res_base = 10'h155;
      end
      tick();
    end
    bus.start = 1'b0;
    n_checks++;
    if (pops != n) begin
      n_fail++;
      $display("FAIL %s pop_count: got %0d expected %0d", name, pops, n);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d expected 1", name, dones);
    end
`ifdef TPU_SEQ_PERF_EN
    n_checks++;
    if (perf_cycles !== 32'(done_c)) begin
      n_fail++;
      $display("FAIL %s perf_cycles: got %0d expected %0d", name, perf_cycles, done_c);
    end
    n_checks++;
    if (perf_stall !== 16'(exp_stall)) begin
      n_fail++;
      $display("FAIL %s perf_stall: got %0d expected %0d", name, perf_stall, exp_stall);
    end
`endif
  endtask

  task automatic test_single_tile();
    run_job("single", 1, 10'h010, 10'h100, 0, 0, 0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_job("three_tiles", 3, 10'h000, 10'h200, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_fifo_stall();
    run_job("stall", 3, 10'h040, 10'h300, 2, 5, 0, 1'b0, 5);
  endtask

  task automatic test_wrap();
    run_job("wrap", 1, 10'h3F8, 10'h3FC, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_zero_and_busy_start();
    run_job("zero_tiles", 0, 10'h123, 10'h321, 0, 0, 0, 1'b0, 0);
    run_job("start_while_busy", 1, 10'h080, 10'h0C0, 0, 0, 10, 1'b0, 0);
  endtask

  task automatic test_reset_mid_job();
    logic [5:0] got_s;
    int dones, strobes;
    issue_start(1, 10'h050, 10'h060);
    for (int c = 1; c < 10; c++) tick();
    n_checks++;
    if (bus.ub_rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_precondition: ub_rd_valid got %b expected 1", bus.ub_rd_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_ub = '0; hold_res = '0;
    got_s = {bus.busy, bus.done, bus.fifo_rd_en, bus.we_rl, bus.ub_rd_valid, bus.res_we};
    n_checks++;
    if (got_s !== 6'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected 000000", got_s);
    end
    dones = 0; strobes = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.done === 1'b1) dones++;
      if (bus.fifo_rd_en || bus.we_rl || bus.ub_rd_valid || bus.res_we || bus.busy) strobes++;
      tick();
    end
    n_checks++;
    if (dones != 0 || strobes != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got done=%0d active=%0d expected 0 and 0", dones, strobes);
    end
    run_job("after_abort", 1, 10'h010, 10'h100, 0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_back_to_back();
    test_fifo_stall();
    test_wrap();
    test_zero_and_busy_start();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
